systolic_frame_ctrl: RTL and testbench

SYSTOLIC_FRAME_CTRL -- requirements
Module: systolic_frame_ctrl

---
 rtl/systolic_ctrl_pkg.sv | 22 ++
 rtl/systolic_out_tracker.sv | 53 +++++
 rtl/systolic_frame_ctrl.sv | 169 ++++++++++++++++
 tb/tb_systolic_frame_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_ctrl_pkg : shared states and default sizing for the         |
// | systolic filter frame controller.            Revision 1.0            |
// +----------------------------------------------------------------------+
package systolic_ctrl_pkg;

   localparam int DEF_DW    = 18;
   localparam int DEF_TAPS  = 16;
   localparam int DEF_LAT   = 40;
   localparam int DEF_LEN_W = 12;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_RUN   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DRAIN = 3'd4
   } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/systolic_out_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_out_tracker : registers filter results, counts them and     |
// | flags the final result of a frame.           Revision 1.0            |
// +----------------------------------------------------------------------+
module systolic_out_tracker #(
   parameter int DW    = 18,
   parameter int LEN_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [DW-1:0]    filt_data,
   input  logic             filt_valid,
   input  logic [LEN_W:0]   exp_cnt,
   input  logic             exp_vld,
   output logic [DW-1:0]    out_data,
   output logic             out_valid,
   output logic             out_last,
   output logic             done
);

   logic [LEN_W:0] cnt;
   logic [LEN_W:0] cnt_inc;
   logic           fwd;

   assign fwd     = enable & filt_valid;
   assign cnt_inc = cnt + (LEN_W+1)'(1);
   // The expected count is only meaningful once the frame's last sample is known.
   assign done    = fwd & exp_vld & (cnt_inc == exp_cnt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= fwd;
         out_last  <= done;
         if (fwd) begin
            out_data <= filt_data;
         end
         if (done) begin
            cnt <= '0;
         end else if (fwd) begin
            cnt <= cnt_inc;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/systolic_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_frame_ctrl : frames samples into an external systolic FIR,  |
// | flushes its taps and forwards the results.   Revision 1.0            |
// +----------------------------------------------------------------------+
module systolic_frame_ctrl
   import systolic_ctrl_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int TAPS  = DEF_TAPS,
   parameter int LAT   = DEF_LAT,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic          Clk_i,
   input  logic          Rst_n_i,
   input  logic [DW-1:0] InData_i,
   input  logic          InValid_i,
   input  logic          InLast_i,
   output logic          InReady_o,
   output logic [DW-1:0] FiltData_o,
   output logic          FiltNd_o,
   input  logic [DW-1:0] FiltData_i,
   input  logic          FiltValid_i,
   output logic [DW-1:0] OutData_o,
   output logic          OutValid_o,
   output logic          OutLast_o,
   output logic          Busy_o,
   output logic          OvfErr_o,
   output logic          SpurErr_o
);

   localparam int CNT_W      = $clog2(TAPS + LAT + 1);
   localparam int FLUSH_LAST = (TAPS > 1) ? TAPS - 2 : 0;
   localparam logic [CNT_W-1:0] INIT_END   = CNT_W'(TAPS + LAT - 1);
   localparam logic [CNT_W-1:0] STROBE_END = CNT_W'(TAPS - 1);
   localparam logic [CNT_W-1:0] FLUSH_END  = CNT_W'(FLUSH_LAST);
   localparam logic [LEN_W-1:0] LEN_MAX    = {LEN_W{1'b1}};
   localparam logic [LEN_W:0]   EXP_ADD    = (LEN_W+1)'(TAPS - 1);

   ctrl_state_t      state;
   ctrl_state_t      state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] len_inc;
   logic [LEN_W:0]   exp_cnt;
   logic             exp_vld;
   logic             accept;
   logic             len_full;
   logic             frame_end;
   logic             fwd_en;
   logic             done;

   assign InReady_o = (state == ST_IDLE) || (state == ST_RUN);
   assign Busy_o    = (state != ST_IDLE);
   assign fwd_en    = (state == ST_RUN) || (state == ST_FLUSH) || (state == ST_DRAIN);
   assign accept    = InValid_i & InReady_o;
   assign len_inc   = len + LEN_W'(1);
   assign len_full  = (len_inc == LEN_MAX);
   // A frame hitting the maximum length is closed as if InLast_i had been seen.
   assign frame_end = accept & (InLast_i | len_full);

   always_ff @(posedge Clk_i) begin
      if (!Rst_n_i) begin
         state <= ST_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: begin
            if (cnt == INIT_END) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_IDLE, ST_RUN: begin
            if (frame_end) begin
               state_nxt = (TAPS > 1) ? ST_FLUSH : ST_DRAIN;
            end else if (accept) begin
               state_nxt = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (cnt == FLUSH_END) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge Clk_i) begin
      if (!Rst_n_i) begin
         cnt        <= '0;
         len        <= '0;
         exp_cnt    <= '0;
         exp_vld    <= 1'b0;
         FiltNd_o   <= 1'b0;
         FiltData_o <= '0;
         OvfErr_o   <= 1'b0;
         SpurErr_o  <= 1'b0;
      end else begin
         FiltNd_o  <= 1'b0;
         OvfErr_o  <= 1'b0;
         SpurErr_o <= (state == ST_IDLE) & FiltValid_i;
         case (state)
            ST_INIT: begin
               // Zero strobes first, then idle long enough for the filter to empty.
               FiltData_o <= '0;
               FiltNd_o   <= (cnt < STROBE_END);
               cnt        <= (cnt == INIT_END) ? '0 : cnt + CNT_W'(1);
            end
            ST_IDLE, ST_RUN: begin
               if (accept) begin
                  FiltData_o <= InData_i;
                  FiltNd_o   <= 1'b1;
                  len        <= len_inc;
                  OvfErr_o   <= len_full & ~InLast_i;
                  if (frame_end) begin
                     exp_cnt <= {1'b0, len_inc} + EXP_ADD;
                     exp_vld <= 1'b1;
                  end
               end
            end
            ST_FLUSH: begin
               FiltData_o <= '0;
               FiltNd_o   <= 1'b1;
               cnt        <= (cnt == FLUSH_END) ? '0 : cnt + CNT_W'(1);
            end
            ST_DRAIN: begin
               if (done) begin
                  len     <= '0;
                  exp_cnt <= '0;
                  exp_vld <= 1'b0;
               end
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

   systolic_out_tracker #(
      .DW    (DW),
      .LEN_W (LEN_W)
   ) u_out_tracker (
      .clk        (Clk_i),
      .rst_n      (Rst_n_i),
      .enable     (fwd_en),
      .filt_data  (FiltData_i),
      .filt_valid (FiltValid_i),
      .exp_cnt    (exp_cnt),
      .exp_vld    (exp_vld),
      .out_data   (OutData_o),
      .out_valid  (OutValid_o),
      .out_last   (OutLast_o),
      .done       (done)
   );

endmodule
`default_nettype wire

// File: tb/tb_systolic_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_systolic_frame_ctrl : frame controller with a two-tap filter      |
// | stand-in, table and random frames.           Revision 1.0           |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_systolic_frame_ctrl;

   localparam int DW     = 18;
   localparam int TAPS   = 16;
   localparam int LAT    = 40;
   localparam int LEN_W  = 4;
   localparam int FL     = 20;
   localparam int MAXLEN = (1 << LEN_W) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [DW-1:0] filt_data_o;
   logic          filt_nd;
   logic [DW-1:0] filt_data_i;
   logic          filt_valid_i;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_last;
   logic          busy;
   logic          ovf;
   logic          spur;

   always #5 clk = ~clk;

   systolic_frame_ctrl #(.DW(DW), .TAPS(TAPS), .LAT(LAT), .LEN_W(LEN_W)) dut (
      .Clk_i(clk), .Rst_n_i(rst_n), .InData_i(in_data), .InValid_i(in_valid),
      .InLast_i(in_last), .InReady_o(in_ready), .FiltData_o(filt_data_o),
      .FiltNd_o(filt_nd), .FiltData_i(filt_data_i), .FiltValid_i(filt_valid_i),
      .OutData_o(out_data), .OutValid_o(out_valid), .OutLast_o(out_last),
      .Busy_o(busy), .OvfErr_o(ovf), .SpurErr_o(spur)
   );

   // Filter stand-in: y = x[n] + x[n-1], fixed latency FL, never reset.
   logic [DW-1:0] f_prev = '0;
   logic [DW-1:0] pd [FL] = '{default: '0};
   logic          pv [FL] = '{default: 1'b0};
   logic          inj = 1'b0;

   always @(posedge clk) begin
      for (int i = FL - 1; i > 0; i--) begin
         pd[i] <= pd[i-1];
         pv[i] <= pv[i-1];
      end
      pv[0] <= filt_nd;
      pd[0] <= filt_data_o + f_prev;
      if (filt_nd) f_prev <= filt_data_o;
   end

   assign filt_valid_i = pv[FL-1] | inj;
   assign filt_data_i  = pd[FL-1];

   logic [DW-1:0] rx_data [$];
   bit            rx_last [$];
   int            ovf_cnt  = 0;
   int            spur_cnt = 0;

   always @(negedge clk) begin
      if (out_valid) begin
         rx_data.push_back(out_data);
         rx_last.push_back(out_last);
      end
      if (ovf)  ovf_cnt++;
      if (spur) spur_cnt++;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic init_check(input string tag);
      int  ready_wait = 0;
      int  strobes = 0;
      int  first = -1;
      int  last_s = -1;
      int  nonzero = 0;
      bit  up = 1'b0;
      for (int c = 1; c <= 300 && !up; c++) begin
         tick();
         if (in_ready) up = 1'b1;
         else begin
            ready_wait++;
            if (filt_nd) begin
               strobes++;
               if (first < 0) first = c;
               last_s = c;
               if (filt_data_o != '0) nonzero++;
            end
         end
      end
      check({tag, " init_strobes"}, strobes, TAPS - 1);
      check({tag, " first_strobe_cycle"}, first, 1);
      check({tag, " strobes_contiguous"}, last_s - first + 1, TAPS - 1);
      check({tag, " strobe_data_zero"}, nonzero, 0);
      check({tag, " ready_low_cycles"}, ready_wait, TAPS - 1 + LAT);
      check({tag, " idle_not_busy"}, busy, 0);
   endtask

   task automatic run_frame(input string tag, input int n, input bit has_last, input bit fixed,
                            input int exp_acc, input int exp_res, input int exp_ovf);
      logic [DW-1:0] offered [$];
      logic [DW-1:0] x [$];
      logic [DW-1:0] exp_q [$];
      logic [DW-1:0] prev;
      int acc = 0;
      int eff;
      int mism = 0;
      int n_lasts = 0;
      int last_idx = -1;
      int ready_busy = 0;
      int busy_at_last = 1;
      bit seen = 1'b0;
      rx_data.delete();
      rx_last.delete();
      ovf_cnt  = 0;
      spur_cnt = 0;
      check({tag, " starts_idle"}, busy, 0);
      for (int i = 0; i < n; i++) begin
         if (!fixed && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
            tick();
         end
         in_data  = fixed ? DW'(18'h1FFFF) : DW'($urandom);
         in_valid = 1'b1;
         in_last  = has_last && (i == n - 1);
         offered.push_back(in_data);
         if (in_ready) acc++;
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
         tick();
         if (out_valid && out_last) begin
            seen = 1'b1;
            busy_at_last = busy;
         end else if (in_ready) ready_busy++;
      end
      repeat (FL + 5) tick();
      // Reference: intended samples (capped at max length) then TAPS-1 zeros, through y = x[n]+x[n-1].
      eff = (n < MAXLEN) ? n : MAXLEN;
      for (int i = 0; i < eff; i++) x.push_back(offered[i]);
      for (int i = 0; i < TAPS - 1; i++) x.push_back('0);
      prev = '0;
      foreach (x[k]) begin
         exp_q.push_back(x[k] + prev);
         prev = x[k];
      end
      for (int k = 0; k < rx_data.size(); k++) begin
         if (k >= exp_q.size() || rx_data[k] != exp_q[k]) mism++;
         if (rx_last[k]) begin
            n_lasts++;
            last_idx = k;
         end
      end
      check({tag, " accepted"}, acc, exp_acc);
      check({tag, " last_seen"}, seen, 1);
      check({tag, " result_count"}, rx_data.size(), exp_res);
      check({tag, " model_count"}, exp_q.size(), rx_data.size());
      check({tag, " data_mismatches"}, mism, 0);
      check({tag, " last_count"}, n_lasts, 1);
      check({tag, " last_index"}, last_idx, exp_res - 1);
      check({tag, " ovf_pulses"}, ovf_cnt, exp_ovf);
      check({tag, " ready_while_busy"}, ready_busy, 0);
      check({tag, " idle_with_last"}, busy_at_last, 0);
      check({tag, " no_spur"}, spur_cnt, 0);
   endtask

   typedef struct {
      string name;
      int    n;
      bit    has_last;
      bit    fixed;
      int    exp_acc;
      int    exp_res;
      int    exp_ovf;
   } fvec_t;

   fvec_t vecs [6];

   initial begin
      vecs[0] = '{"four_1ffff",   4, 1'b1, 1'b1,  4, 19, 0};
      vecs[1] = '{"single",       1, 1'b1, 0,     1, 16, 0};
      vecs[2] = '{"single_again", 1, 1'b1, 0,     1, 16, 0};
      vecs[3] = '{"ovf_cont",    20, 1'b0, 1'b1, 15, 30, 1};
      vecs[4] = '{"len14_last",  14, 1'b1, 0,    14, 29, 0};
      vecs[5] = '{"len15_last",  15, 1'b1, 0,    15, 30, 0};

      rst_n    = 1'b0;
      in_data  = '0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (3) tick();
      check("rst in_ready", in_ready, 0);
      check("rst filt_nd", filt_nd, 0);
      check("rst filt_data", filt_data_o, 0);
      check("rst out_valid", out_valid, 0);
      check("rst out_last", out_last, 0);
      check("rst out_data", out_data, 0);
      check("rst ovf", ovf, 0);
      check("rst spur", spur, 0);
      check("rst busy", busy, 1);
      rst_n = 1'b1;
      init_check("boot");
      check("boot no_spur", spur_cnt, 0);
      check("boot no_output", rx_data.size(), 0);

      foreach (vecs[v]) begin
         run_frame(vecs[v].name, vecs[v].n, vecs[v].has_last, vecs[v].fixed,
                   vecs[v].exp_acc, vecs[v].exp_res, vecs[v].exp_ovf);
      end

      // Filter result arriving while idle.
      rx_data.delete();
      rx_last.delete();
      spur_cnt = 0;
      inj = 1'b1;
      tick();
      inj = 1'b0;
      repeat (3) tick();
      check("spur pulse", spur_cnt, 1);
      check("spur no_output", rx_data.size(), 0);
      check("spur still_idle", busy, 0);

      for (int r = 0; r < 6; r++) begin
         int n;
         bit hl;
         int eff;
         bit ov;
         n   = $urandom_range(1, MAXLEN + 3);
         hl  = (n < MAXLEN) ? 1'b1 : 1'($urandom_range(0, 1));
         eff = (n < MAXLEN) ? n : MAXLEN;
         ov  = (n > MAXLEN) || (n == MAXLEN && !hl);
         run_frame($sformatf("rand%0d_n%0d", r, n), n, hl, 1'b0, eff, eff + TAPS - 1, int'(ov));
      end

      // Reset pulse in the middle of a frame.
      for (int i = 0; i < 5; i++) begin
         in_data  = DW'($urandom);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      rx_data.delete();
      rx_last.delete();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst busy", busy, 1);
      check("midrst in_ready", in_ready, 0);
      check("midrst filt_nd", filt_nd, 0);
      init_check("midrst");
      repeat (5) tick();
      check("midrst no_output", rx_data.size(), 0);
      run_frame("after_rst", 3, 1'b1, 1'b0, 3, 18, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
